// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit segment per stage, with the carry
// registered between stages and a global valid/ready stall applied to every stage at once.
module rca_pipe_addsub #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SEG   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf
);

   localparam int unsigned NSTG = WIDTH / SEG;

   // Level 0 is the capture register; level j holds the result of stage j-1.
   logic [NSTG:0]    vld_q, vld_d;
   logic [NSTG:0]    c_q, c_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] a_q [NSTG];
   logic [WIDTH-1:0] a_d [NSTG];
   logic [WIDTH-1:0] b_q [NSTG];
   logic [WIDTH-1:0] b_d [NSTG];
   logic [WIDTH-1:0] s_q [NSTG+1];
   logic [WIDTH-1:0] s_d [NSTG+1];
   logic             adv;
   logic             cy, cm;

   assign adv       = !vld_q[NSTG] || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_q[NSTG];
   assign S         = s_q[NSTG];
   assign Cout      = c_q[NSTG];
   assign Ovf       = ovf_q;

   always_comb begin
      cy     = 1'b0;
      cm     = 1'b0;
      vld_d  = {vld_q[NSTG-1:0], in_valid};
      c_d    = '0;
      a_d[0] = A;
      b_d[0] = sub ? ~B : B;
      c_d[0] = sub ? 1'b1 : Cin;
      s_d[0] = '0;
      for (int j = 1; j < NSTG; j++) begin
         a_d[j] = a_q[j-1];
         b_d[j] = b_q[j-1];
      end
      for (int j = 1; j <= NSTG; j++) begin
         s_d[j] = s_q[j-1];
         cy     = c_q[j-1];
         for (int i = 0; i < SEG; i++) begin
            // cm ends up as the carry into the segment MSB
            cm = cy;
            s_d[j][(j-1)*SEG+i] = a_q[j-1][(j-1)*SEG+i] ^ b_q[j-1][(j-1)*SEG+i] ^ cy;
            cy = (a_q[j-1][(j-1)*SEG+i] & b_q[j-1][(j-1)*SEG+i]) |
                 (cy & (a_q[j-1][(j-1)*SEG+i] ^ b_q[j-1][(j-1)*SEG+i]));
         end
         c_d[j] = cy;
      end
      // After the loop cy/cm belong to the top segment
      ovf_d = cm ^ cy;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         c_q   <= '0;
         ovf_q <= 1'b0;
         for (int j = 0; j < NSTG; j++) begin
            a_q[j] <= '0;
            b_q[j] <= '0;
         end
         for (int j = 0; j <= NSTG; j++) begin
            s_q[j] <= '0;
         end
      end else if (adv) begin
         vld_q <= vld_d;
         c_q   <= c_d;
         ovf_q <= ovf_d;
         a_q   <= a_d;
         b_q   <= b_d;
         s_q   <= s_d;
      end
   end

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Self-checking bench for rca_pipe_addsub: directed vector table, random streams checked
// against an arithmetic reference model, backpressure and mid-stream reset sequences.
module tb_rca_pipe_addsub;

   localparam int W  = 32;
   localparam int NS = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         Cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] S;
   logic         Cout;
   logic         Ovf;

   typedef struct {
      logic [31:0] s;
      logic        cout;
      logic        ovf;
      int          acc;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sb;
      logic [31:0] s;
      logic        cout;
      logic        ovf;
   } vec_t;

   exp_t q[$];
   int   out_cyc[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   lat_last = -1;
   int   outs_seen = 0;
   vec_t tbl[7];

   rca_pipe_addsub #(.WIDTH(W), .SEG(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .Cout      (Cout),
      .Ovf       (Ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // Reference: plain unsigned/signed arithmetic, independent of segmenting
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic c, input logic s);
      exp_t        e;
      logic [32:0] t;
      longint      r;
      if (s) begin
         e.s    = a - b;
         e.cout = (a >= b);
         r      = longint'($signed(a)) - longint'($signed(b));
      end else begin
         t      = {1'b0, a} + {1'b0, b} + 33'(c);
         e.s    = t[31:0];
         e.cout = t[32];
         r      = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
      end
      e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      e.acc = 0;
      return e;
   endfunction

   // Scoreboard: every consumed result is compared with the oldest expectation
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got result S=0x%08h, expected no result", S);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("S", S, e.s);
            chk("Cout", 32'(Cout), 32'(e.cout));
            chk("Ovf", 32'(Ovf), 32'(e.ovf));
            lat_last = cyc - e.acc;
         end
         outs_seen++;
         out_cyc.push_back(cyc);
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic s, input exp_t e);
      int   n = 0;
      logic ok = 1'b0;
      A = a; B = b; Cin = c; sub = s; in_valid = 1'b1;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, expected accept");
      end else begin
         e.acc = cyc;
         q.push_back(e);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d results pending, expected 0", q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_rand();
      logic [31:0] a, b;
      logic        c, s;
      a = $urandom;
      b = $urandom;
      c = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      send(a, b, c, s, model(a, b, c, s));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int   first_acc;
      int   base;
      int   cnt;
      logic [31:0] held;
      exp_t e;

      tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      tbl[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      tbl[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      tbl[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      tbl[5] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
      tbl[6] = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'h2143_6587, 1'b0, 1'b0};

      // Reset state
      #1 rst_n = 1'b0;
      #2;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_S", S, 0);
      chk("rst_Cout", 32'(Cout), 0);
      chk("rst_Ovf", 32'(Ovf), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Directed vectors, one at a time, with latency check
      foreach (tbl[i]) begin
         e.s = tbl[i].s; e.cout = tbl[i].cout; e.ovf = tbl[i].ovf; e.acc = 0;
         send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sb, e);
         in_valid = 1'b0;
         drain();
         chk($sformatf("latency_vec%0d", i), lat_last, NS);
      end

      // Back-to-back throughput: 20 results on consecutive cycles
      out_cyc.delete();
      send_rand();
      first_acc = cyc;
      for (int i = 1; i < 20; i++) send_rand();
      in_valid = 1'b0;
      chk("tput_accept_span", cyc - first_acc, 19);
      drain();
      chk("tput_count", out_cyc.size(), 20);
      foreach (out_cyc[i]) chk($sformatf("tput_cyc%0d", i), out_cyc[i], first_acc + NS + i);

      // Backpressure: 5-cycle stall once the first result is presented
      base = outs_seen;
      fork
         begin
            for (int i = 0; i < 12; i++) send_rand();
            in_valid = 1'b0;
         end
         begin
            int n = 0;
            while (!out_valid && n < 100) begin
               @(posedge clk);
               #1;
               n++;
            end
            out_ready = 1'b0;
            held = S;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               chk("stall_in_ready", 32'(in_ready), 0);
               chk("stall_out_valid", 32'(out_valid), 1);
               chk("stall_S_held", S, held);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_count", outs_seen - base, 12);

      // Reset mid-stream with one result held at the output and three behind it
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_rand();
      in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 50) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk("pre_reset_valid", 32'(out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 0);
      chk("mid_rst_S", S, 0);
      chk("mid_rst_Cout", 32'(Cout), 0);
      chk("mid_rst_Ovf", 32'(Ovf), 0);
      q.delete();
      out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 1);
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("no_stale_results", cnt, 0);
      @(posedge clk);
      #1;
      send(32'hDEAD_BEEF, 32'h0000_0011, 1'b1, 1'b0, model(32'hDEAD_BEEF, 32'h11, 1'b1, 1'b0));
      in_valid = 1'b0;
      drain();
      chk("post_rst_latency", lat_last, NS);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rca_pipe_addsub.md
Name: rca_pipe_addsub

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; next generation of the team's 32-bit segmented RCA.
- Splits the operands into SEG-bit segments and ripples one segment per clock stage, with carry registered between stages.
- Accepts one operation per cycle through a valid/ready handshake and supports backpressure.
- Sits in the datapath wherever wide additions must close timing at high clock rates, including multiplier partial-product accumulation.

Parameters:
- WIDTH, 32: operand and sum width in bits; must be a multiple of SEG.
- SEG, 4: bits added per pipeline stage; NSTG = WIDTH/SEG stages (8 at defaults).

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operation presented.
- in_ready, output, 1: block can accept an operation this cycle.
- A, input, WIDTH: operand A.
- B, input, WIDTH: operand B.
- Cin, input, 1: carry in; ignored when sub=1.
- sub, input, 1: 0 computes A+B+Cin; 1 computes A-B.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- S, output, WIDTH: sum or difference.
- Cout, output, 1: carry out of the MSB; for sub, 1 means no borrow.
- Ovf, output, 1: signed overflow.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: while rst_n=0, every stage valid bit, out_valid, S, Cout, Ovf and all pipeline data/carry registers are 0.
- Reset mid-operation: all in-flight operations are discarded and none is emitted. After release, in_ready=1 on the first cycle.
- Transfer rules: input is accepted when in_valid&&in_ready. Output is consumed when out_valid&&out_ready.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv, purely combinational; there is no combinational path from in_valid.
  - When adv=0, every stage register holds, including valid bits, operands, partial sums and carries.
  - When adv=1, all stages shift by one and stage0 loads the accepted input, or a bubble with valid=0.
- Subtract mode: B is replaced by ~B and Cin by 1 when sub=1, applied at stage0 capture. The sub bit travels with the operation.
- Stage k (k=0..NSTG-1) computes bits [k*SEG+SEG-1 : k*SEG] from:
  - the operand segments, skewed through delay registers;
  - the registered carry from stage k-1 (stage0 uses the effective Cin).
  - Each stage's sum segment and carry-out are registered.
  - Completed low segments are carried forward unchanged (output deskew), so all WIDTH bits of S appear together.
- Latency: the operation accepted at edge t has out_valid=1 after edge t+NSTG, provided no stall. Each stall cycle adds exactly one cycle.
- Throughput: 1 operation/cycle under continuous out_ready=1, with no bubbles inserted.
- Result flags:
  - Cout = carry out of bit WIDTH-1.
  - Ovf = carry into bit WIDTH-1 XOR Cout.
  - Both are registered alongside S.
- Arithmetic is modulo 2^WIDTH.
- Simultaneous events: when the last stage holds valid data, out_ready=1 and in_valid=1, the result leaves and a new input enters in the same cycle.
- Bubbles: bubbles propagate with valid=0. S/Cout/Ovf are don't-care when out_valid=0, but must not be X after reset.
- Stability: while out_valid=1 and out_ready=0, S/Cout/Ovf are held stable.
- Ordering: results emerge in acceptance order; there is no reordering.

Test Plan:
- Single add (WIDTH=32, SEG=4): A=0xFFFF_FFFF, B=0x0000_0001, Cin=0, sub=0, out_ready=1.
  - Required: out_valid exactly 8 cycles after accept; S=0x0000_0000, Cout=1, Ovf=0.
- Full carry ripple plus signed overflow: A=0x7FFF_FFFF, B=0, Cin=1.
  - Required: S=0x8000_0000, Cout=0, Ovf=1.
- Subtract: A=5, B=7, sub=1, then A=0x8000_0000, B=1, sub=1.
  - Required, first result: S=0xFFFF_FFFE, Cout=0, Ovf=0.
  - Required, second result: S=0x7FFF_FFFF, Cout=1, Ovf=1.
- Back-to-back throughput: 20 consecutive random operations with in_valid=1 and out_ready=1.
  - Required: 20 results on consecutive cycles starting at cycle 8, matching the reference model in order.
- Backpressure: stream 12 operations and hold out_ready=0 for 5 cycles once out_valid rises.
  - Required: in_ready=0 during the stall and S held stable; no loss or duplication; all 12 results correct and in order.
- Reset mid-stream: assert rst_n=0 asynchronously (between edges) with 4 operations in flight, then release.
  - Required: out_valid drops immediately and all outputs read 0.
  - Required after release: no stale result emerges; a new operation completes 8 cycles after its accept.
